ias_fetch_unit: RTL and testbench

- Instruction-fetch sequencer for the IAS datapath.
- Sits directly upstream of the 8-bit program-counter register and drives its clear/load/inc controls.
- Consumes the PC output, reads 40-bit memory words through a req/ack handshake, and holds the right-hand instruction in an instruction buffer (IBR).
- Issues 20-bit instructions (left half, then right half) to decode/execute over a valid/ready handshake; handles jumps and halt.

---
 rtl/ias_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_ias_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ias_fetch_unit.sv
// IAS instruction-fetch sequencer: drives PC strobes, fetches 40-bit words,
// and issues the left then right 20-bit instruction over a valid/ready handshake.
module ias_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 40,
  parameter int OPC_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             pc_value,
  output logic                          pc_clear,
  output logic                          pc_load,
  output logic                          pc_inc,
  output logic [ADDR_W-1:0]             pc_load_value,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  input  logic [WORD_W-1:0]             mem_rdata,
  output logic                          ir_valid,
  input  logic                          ir_ready,
  output logic [OPC_W-1:0]              ir_opcode,
  output logic [WORD_W/2-OPC_W-1:0]     ir_addr,
  input  logic                          jump_req,
  input  logic [ADDR_W-1:0]             jump_addr,
  input  logic                          jump_right,
  input  logic                          halt,
  output logic                          halted
);

  localparam int INS_W = WORD_W / 2;
  localparam int AF_W  = INS_W - OPC_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE_L, S_ISSUE_R, S_HALTED
  } state_t;

  state_t              state_q, state_d;
  logic [INS_W-1:0]    left_q, left_d;
  logic [INS_W-1:0]    ibr_q, ibr_d;
  logic                jump_pending_q, jump_pending_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                pend_right_q, pend_right_d;
  logic                right_only_q, right_only_d;
  logic                halt_pending_q, halt_pending_d;
  logic                reload_q, reload_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      left_q         <= '0;
      ibr_q          <= '0;
      jump_pending_q <= 1'b0;
      pend_addr_q    <= '0;
      pend_right_q   <= 1'b0;
      right_only_q   <= 1'b0;
      halt_pending_q <= 1'b0;
      reload_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      left_q         <= left_d;
      ibr_q          <= ibr_d;
      jump_pending_q <= jump_pending_d;
      pend_addr_q    <= pend_addr_d;
      pend_right_q   <= pend_right_d;
      right_only_q   <= right_only_d;
      halt_pending_q <= halt_pending_d;
      reload_q       <= reload_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    left_d         = left_q;
    ibr_d          = ibr_q;
    jump_pending_d = jump_pending_q;
    pend_addr_d    = pend_addr_q;
    pend_right_d   = pend_right_q;
    right_only_d   = right_only_q;
    halt_pending_d = halt_pending_q;
    reload_d       = reload_q;
    pc_clear       = 1'b0;
    pc_load        = 1'b0;
    pc_inc         = 1'b0;
    pc_load_value  = '0;
    mem_req        = 1'b0;
    mem_addr       = '0;
    ir_valid       = 1'b0;
    ir_opcode      = '0;
    ir_addr        = '0;
    halted         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !reset) begin
          pc_clear = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        if (reload_q) begin
          // Idle cycle after a discarded word: redirect the PC with no request up.
          reload_d       = 1'b0;
          jump_pending_d = 1'b0;
          if (halt) begin
            state_d = S_HALTED;
          end else begin
            pc_load       = 1'b1;
            pc_load_value = jump_req ? jump_addr : pend_addr_q;
            right_only_d  = jump_req ? jump_right : pend_right_q;
          end
        end else begin
          mem_req  = 1'b1;
          mem_addr = pc_value;
          if (halt) begin
            halt_pending_d = 1'b1;
          end else if (jump_req) begin
            jump_pending_d = 1'b1;
            pend_addr_d    = jump_addr;
            pend_right_d   = jump_right;
          end
          if (mem_ack) begin
            if (halt_pending_q || halt) begin
              halt_pending_d = 1'b0;
              jump_pending_d = 1'b0;
              state_d        = S_HALTED;
            end else if (jump_pending_q || jump_req) begin
              reload_d = 1'b1;
            end else begin
              left_d       = mem_rdata[WORD_W-1:INS_W];
              ibr_d        = mem_rdata[INS_W-1:0];
              right_only_d = 1'b0;
              state_d      = right_only_q ? S_ISSUE_R : S_ISSUE_L;
            end
          end
        end
      end

      S_ISSUE_L, S_ISSUE_R: begin
        ir_valid  = 1'b1;
        ir_opcode = (state_q == S_ISSUE_L) ? left_q[INS_W-1:AF_W] : ibr_q[INS_W-1:AF_W];
        ir_addr   = (state_q == S_ISSUE_L) ? left_q[AF_W-1:0]     : ibr_q[AF_W-1:0];
        if (halt) begin
          state_d = S_HALTED;
        end else if (jump_req) begin
          pc_load       = 1'b1;
          pc_load_value = jump_addr;
          right_only_d  = jump_right;
          ibr_d         = '0;
          state_d       = S_FETCH;
        end else if (ir_ready) begin
          if (state_q == S_ISSUE_L) begin
            state_d = S_ISSUE_R;
          end else begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_HALTED: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ias_fetch_unit.sv
// Directed bench for ias_fetch_unit with a PC register model and a
// memory responder whose ack latency is adjustable per step.
module tb_ias_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pc_value;
  logic        pc_clear, pc_load, pc_inc;
  logic [7:0]  pc_load_value;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [39:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  ir_opcode;
  logic [11:0] ir_addr;
  logic        jump_req;
  logic [7:0]  jump_addr;
  logic        jump_right;
  logic        halt;
  logic        halted;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int ack_cnt = 0;
  logic [39:0] mem [256];

  ias_fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .pc_value(pc_value),
    .pc_clear(pc_clear), .pc_load(pc_load), .pc_inc(pc_inc),
    .pc_load_value(pc_load_value), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .ir_opcode(ir_opcode), .ir_addr(ir_addr),
    .jump_req(jump_req), .jump_addr(jump_addr), .jump_right(jump_right),
    .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  // Program-counter register that the fetch unit steers
  always @(posedge clk or posedge reset) begin
    if (reset)        pc_value <= 8'd0;
    else if (pc_clear) pc_value <= 8'd0;
    else if (pc_load)  pc_value <= pc_load_value;
    else if (pc_inc)   pc_value <= pc_value + 8'd1;
  end

  always @(posedge clk) begin
    if (!mem_req || mem_ack) ack_cnt <= 0;
    else                     ack_cnt <= ack_cnt + 1;
  end
  assign mem_ack   = mem_req && (ack_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 40'h0;
    mem[8'h00] = 40'h01_00A_05_00B;
    mem[8'h01] = 40'h02_111_03_222;
    mem[8'h02] = 40'h04_333_06_444;
    mem[8'h20] = 40'h07_555_08_666;
    mem[8'h21] = 40'hEE_DDD_CC_BBB;
    mem[8'h40] = 40'h09_777_0A_888;
    mem[8'hFF] = 40'h0B_999_0C_AAA;

    reset = 1'b1; start = 1'b1; ir_ready = 1'b0; halt = 1'b0;
    jump_req = 1'b0; jump_addr = 8'h0; jump_right = 1'b0;
    tick(); tick();
    #1;
    chk("rst_pc_clear", pc_clear, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_halted", halted, 0);
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // basic fetch and issue of word 0
    start = 1'b1; #1;
    chk("start_pc_clear", pc_clear, 1);
    tick(); start = 1'b0; ir_ready = 1'b1; #1;
    chk("f0_req", mem_req, 1);
    chk("f0_addr", mem_addr, 0);
    tick(); #1;
    chk("l0_valid", ir_valid, 1);
    chk("l0_opc", ir_opcode, 8'h01);
    chk("l0_addr", ir_addr, 12'h00A);
    chk("l0_req", mem_req, 0);
    tick(); #1;
    chk("r0_opc", ir_opcode, 8'h05);
    chk("r0_addr", ir_addr, 12'h00B);
    chk("r0_inc", pc_inc, 1);
    tick(); ir_ready = 1'b0; #1;
    chk("f1_addr", mem_addr, 1);
    chk("f1_inc", pc_inc, 0);

    // stall in ISSUE_L
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", ir_valid, 1);
      chk("stall_opc", ir_opcode, 8'h02);
      chk("stall_addr", ir_addr, 12'h111);
      chk("stall_inc", pc_inc, 0);
      chk("stall_req", mem_req, 0);
      tick();
    end
    ir_ready = 1'b1;
    tick(); #1;
    chk("r1_opc", ir_opcode, 8'h03);
    chk("r1_inc", pc_inc, 1);
    tick(); #1;
    chk("f2_addr", mem_addr, 2);

    // jump in ISSUE_L to the right half of word 0x20
    tick();
    jump_req = 1'b1; jump_addr = 8'h20; jump_right = 1'b1; #1;
    chk("jl_load", pc_load, 1);
    chk("jl_value", pc_load_value, 8'h20);
    chk("jl_inc", pc_inc, 0);
    tick(); jump_req = 1'b0; #1;
    chk("jl_valid_drop", ir_valid, 0);
    chk("jl_fetch_addr", mem_addr, 8'h20);
    chk("jl_load_clr", pc_load_value, 0);
    tick(); #1;
    chk("jr_valid", ir_valid, 1);
    chk("jr_opc", ir_opcode, 8'h08);
    chk("jr_addr", ir_addr, 12'h666);
    chk("jr_inc", pc_inc, 1);
    ack_delay = 3;

    // jump during a slow fetch at 0x21
    tick();
    jump_req = 1'b1; jump_addr = 8'h40; jump_right = 1'b0; #1;
    chk("jf_addr0", mem_addr, 8'h21);
    chk("jf_ack0", mem_ack, 0);
    chk("jf_load0", pc_load, 0);
    tick(); jump_req = 1'b0; #1;
    chk("jf_addr1", mem_addr, 8'h21);
    tick(); #1;
    chk("jf_addr2", mem_addr, 8'h21);
    tick(); #1;
    chk("jf_ack3", mem_ack, 1);
    chk("jf_load3", pc_load, 0);
    tick(); #1;
    chk("jf_reload_req", mem_req, 0);
    chk("jf_reload_load", pc_load, 1);
    chk("jf_reload_val", pc_load_value, 8'h40);
    chk("jf_reload_valid", ir_valid, 0);
    ack_delay = 0;
    tick(); #1;
    chk("jf_refetch_req", mem_req, 1);
    chk("jf_refetch_addr", mem_addr, 8'h40);
    tick(); #1;
    chk("jf_l_opc", ir_opcode, 8'h09);

    // PC wrap: right half of 0xFF then fetch at 0
    jump_req = 1'b1; jump_addr = 8'hFF; jump_right = 1'b1;
    tick(); jump_req = 1'b0; #1;
    chk("wrap_addr_ff", mem_addr, 8'hFF);
    tick(); #1;
    chk("wrap_r_opc", ir_opcode, 8'h0C);
    chk("wrap_inc", pc_inc, 1);
    tick(); #1;
    chk("wrap_addr_0", mem_addr, 8'h00);
    chk("wrap_req", mem_req, 1);
    tick(); #1;
    chk("wrap_l_opc", ir_opcode, 8'h01);

    // halt in ISSUE_R
    tick();
    halt = 1'b1; jump_req = 1'b1; jump_addr = 8'h55; #1;
    chk("halt_r_inc", pc_inc, 0);
    chk("halt_r_load", pc_load, 0);
    tick(); halt = 1'b0; jump_req = 1'b0; #1;
    chk("halted", halted, 1);
    chk("halted_valid", ir_valid, 0);
    chk("halted_req", mem_req, 0);
    start = 1'b1; jump_req = 1'b1; #1;
    chk("halted_no_clear", pc_clear, 0);
    chk("halted_no_load", pc_load, 0);
    tick(); start = 1'b0; jump_req = 1'b0; #1;
    chk("halted_stays", halted, 1);

    // reset mid-FETCH
    reset = 1'b1; #1;
    chk("rst_leaves_halt", halted, 0);
    tick(); reset = 1'b0; ack_delay = 5;
    start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("mid_req", mem_req, 1);
    #1 reset = 1'b1; #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_halted", halted, 0);
    tick(); reset = 1'b0;
    tick(); #1;
    chk("mid_idle_req", mem_req, 0);
    chk("mid_idle_valid", ir_valid, 0);

    // halt during FETCH waits for ack
    ack_delay = 2; start = 1'b1;
    tick(); start = 1'b0; halt = 1'b1; #1;
    chk("hf_req", mem_req, 1);
    tick(); halt = 1'b0; #1;
    chk("hf_req_held", mem_req, 1);
    chk("hf_not_halted", halted, 0);
    tick(); #1;
    chk("hf_ack", mem_ack, 1);
    tick(); #1;
    chk("hf_halted", halted, 1);
    chk("hf_valid", ir_valid, 0);
    chk("hf_req_drop", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
